channel_acq_responder_selftrig: RTL

CHANNEL_ACQ_RESPONDER_SELFTRIG -- requirements
Module: channel_acq_responder_selftrig

---
 rtl/channel_acq_responder_selftrig.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/channel_acq_responder_selftrig.sv
// channel_acq_responder_selftrig
//   Self-triggered acquisition responder for one detector channel. On a
//   discriminator trigger it captures EVENT_LEN consecutive ADC samples into
//   a local window. It then drains the window to the DDR3 write port. Close
//   requests (enable falling) and buffer flips from the controller are
//   handled without tearing an event in progress.
//
// Ports
//   clk, reset         : channel clock; synchronous active-high reset
//   acq_enable         : acquisition enable; a 1->0 transition requests a close
//   acq_buffer_write   : write-buffer select; any toggle requests a buffer flip
//   acq_done           : one-cycle pulse when a close request has completed
//   self_trig          : discriminator trigger, level-sampled every cycle
//   adc_data[15:0]     : ADC sample, new every cycle
//   wr_valid/wr_ready  : write handshake (see below)
//   wr_addr[ADDR_W-1:0]: {buf_sel, word_ptr}
//   wr_data[15:0]      : sample word being written
//   event_count[15:0]  : events fully written into the current buffer
//   missed_count[15:0] : dropped triggers, saturating
//   buf_full           : current buffer cannot take another whole event
//   state[4:0]         : one-hot state {HOLD, DRAIN, CAPTURE, ARMED, IDLE}
//
// Handshake: a word transfers on a rising clk edge where wr_valid and
// wr_ready are both high. Once wr_valid is raised, wr_addr and wr_data stay
// constant until that transfer, and wr_valid does not drop before it.
module channel_acq_responder_selftrig #(
  parameter int EVENT_LEN = 8,
  parameter int ADDR_W    = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acq_enable,
  input  logic              acq_buffer_write,
  output logic              acq_done,
  input  logic              self_trig,
  input  logic [15:0]       adc_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [15:0]       event_count,
  output logic [15:0]       missed_count,
  output logic              buf_full,
  output logic [4:0]        state
);

  localparam int PW = ADDR_W - 1;          // word pointer bits within a buffer
  localparam int CW = $clog2(EVENT_LEN);   // window index bits
  localparam int SW = PW + 8;              // room for ptr + EVENT_LEN without overflow

  localparam logic [4:0] S_IDLE    = 5'b00001;
  localparam logic [4:0] S_ARMED   = 5'b00010;
  localparam logic [4:0] S_CAPTURE = 5'b00100;
  localparam logic [4:0] S_DRAIN   = 5'b01000;
  localparam logic [4:0] S_HOLD    = 5'b10000;

  localparam logic [SW-1:0] BUF_WORDS = SW'(1) << PW;
  localparam logic [CW-1:0] LAST_IDX  = CW'(EVENT_LEN - 1);

  logic [4:0]        r_state;
  logic              r_en, r_en_prev;
  logic              r_buf, r_buf_prev;
  logic              r_buf_sel;
  // One bit wider than the in-buffer address so a completely full buffer
  // (ptr == 2^PW) is representable and the pointer never wraps.
  logic [PW:0]       r_word_ptr;
  logic [15:0]       r_win [EVENT_LEN];
  logic [CW-1:0]     r_cap_cnt;
  logic [CW-1:0]     r_idx;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic [15:0]       r_event_count;
  logic [15:0]       r_missed_count;
  logic              r_done;
  logic              r_close_pending;
  logic              r_flip_pending;

  logic              w_close_req, w_flip, w_space, w_start, w_miss;
  logic              w_close_now, w_flip_now;
  logic [SW-1:0]     w_ptr_plus;
  logic [PW:0]       w_ptr_inc;
  logic [CW-1:0]     w_idx_next;

  assign w_close_req = r_en_prev & ~r_en;
  assign w_flip      = r_buf ^ r_buf_prev;
  assign w_ptr_plus  = SW'(r_word_ptr) + SW'(EVENT_LEN);
  assign w_space     = (w_ptr_plus <= BUF_WORDS);
  assign w_ptr_inc   = r_word_ptr + (PW+1)'(1);
  assign w_idx_next  = r_idx + CW'(1);
  // A close or flip that lands in the same cycle as the event end still counts.
  assign w_close_now = r_close_pending | w_close_req;
  assign w_flip_now  = r_flip_pending | w_flip;

  // A trigger starts an event only from a clean ARMED cycle; close, flip or a
  // dropped enable take priority and the trigger is then counted as missed.
  assign w_start = (r_state == S_ARMED) & r_en & ~w_close_req & ~w_flip &
                   self_trig & w_space;
  assign w_miss  = self_trig &
                   ((r_state == S_CAPTURE) | (r_state == S_DRAIN) |
                    (r_state == S_HOLD) | ((r_state == S_ARMED) & ~w_start));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_en            <= 1'b0;
      r_en_prev       <= 1'b0;
      r_buf           <= acq_buffer_write;
      r_buf_prev      <= acq_buffer_write;
      r_buf_sel       <= acq_buffer_write;
      r_word_ptr      <= '0;
      r_cap_cnt       <= '0;
      r_idx           <= '0;
      r_wr_valid      <= 1'b0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
      r_event_count   <= '0;
      r_missed_count  <= '0;
      r_done          <= 1'b0;
      r_close_pending <= 1'b0;
      r_flip_pending  <= 1'b0;
    end else begin
      r_en       <= acq_enable;
      r_en_prev  <= r_en;
      r_buf      <= acq_buffer_write;
      r_buf_prev <= r_buf;
      r_done     <= 1'b0;

      if (w_miss && (r_missed_count != 16'hFFFF))
        r_missed_count <= r_missed_count + 16'd1;

      case (r_state)
        S_IDLE, S_ARMED: begin
          if (w_close_req) begin
            // Close first; a simultaneous flip is applied from HOLD.
            r_state        <= S_HOLD;
            r_done         <= 1'b1;
            r_flip_pending <= w_flip;
          end else if (w_flip) begin
            r_word_ptr     <= '0;
            r_event_count  <= '0;
            r_buf_sel      <= r_buf;
            r_flip_pending <= 1'b0;
            r_state        <= r_en ? S_ARMED : S_IDLE;
          end else if (r_state == S_IDLE) begin
            if (r_en) r_state <= S_ARMED;
          end else if (!r_en) begin
            r_state <= S_IDLE;
          end else if (w_start) begin
            r_state   <= S_CAPTURE;
            r_cap_cnt <= CW'(1);
          end
        end

        S_CAPTURE: begin
          if (w_close_req) r_close_pending <= 1'b1;
          if (w_flip)      r_flip_pending  <= 1'b1;
          if (r_cap_cnt == LAST_IDX) begin
            r_state <= S_DRAIN;
            r_idx   <= '0;
          end else begin
            r_cap_cnt <= r_cap_cnt + CW'(1);
          end
        end

        S_DRAIN: begin
          if (w_close_req) r_close_pending <= 1'b1;
          if (w_flip)      r_flip_pending  <= 1'b1;
          if (!r_wr_valid) begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= {r_buf_sel, r_word_ptr[PW-1:0]};
            r_wr_data  <= r_win[r_idx];
          end else if (wr_ready) begin
            r_word_ptr <= w_ptr_inc;
            if (r_idx == LAST_IDX) begin
              r_wr_valid    <= 1'b0;
              r_event_count <= r_event_count + 16'd1;
              if (w_close_now) begin
                r_state         <= S_HOLD;
                r_done          <= 1'b1;
                r_close_pending <= 1'b0;
                r_flip_pending  <= w_flip_now;
              end else if (w_flip_now) begin
                // Event finished in the old buffer; now switch.
                r_word_ptr     <= '0;
                r_event_count  <= '0;
                r_buf_sel      <= r_buf;
                r_flip_pending <= 1'b0;
                r_state        <= r_en ? S_ARMED : S_IDLE;
              end else begin
                r_state <= S_ARMED;
              end
            end else begin
              r_idx     <= w_idx_next;
              r_wr_addr <= {r_buf_sel, w_ptr_inc[PW-1:0]};
              r_wr_data <= r_win[w_idx_next];
            end
          end
        end

        S_HOLD: begin
          if (w_flip_now) begin
            r_word_ptr     <= '0;
            r_event_count  <= '0;
            r_buf_sel      <= r_buf;
            r_flip_pending <= 1'b0;
            r_state        <= r_en ? S_ARMED : S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sample window: slot 0 on the trigger cycle, then one slot per CAPTURE cycle.
  always_ff @(posedge clk) begin
    if (w_start)
      r_win[0] <= adc_data;
    else if (r_state == S_CAPTURE)
      r_win[r_cap_cnt] <= adc_data;
  end

  assign acq_done     = r_done;
  assign wr_valid     = r_wr_valid;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign event_count  = r_event_count;
  assign missed_count = r_missed_count;
  assign buf_full     = ~w_space;
  assign state        = r_state;

endmodule
